// File: rtl/rotor_sequencer.sv
// rotor_sequencer
//
// Purpose:
//   Sequential front end for letter_shifter. Accepts one letter per cycle
//   over a valid/ready handshake and keeps three rotor positions. For every
//   accepted letter it registers the letter, its mode bit and the rotor
//   offset (pos0 + pos1 + pos2) mod 26 into a one-entry output buffer. It
//   then steps the rotors odometer-style, with carries at NOTCH0/NOTCH1.
//   Non-letters (values above 25) pass through with offset 0 and do not
//   step the rotors.
//
// Parameters:
//   NOTCH0  rotor 0 position whose step also carries into rotor 1
//   NOTCH1  rotor 1 position that passes a rotor 0 carry on to rotor 2
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset, clears all state
//   load         in   load init_pos0..2 into the rotors (priority over accept)
//   init_pos0..2 in   8-bit initial positions, legal range 0..25
//   load_err     out  one-cycle pulse after a rejected load
//   char_valid   in   upstream letter available
//   char_ready   out  block can accept a letter this cycle (combinational)
//   char_in      in   8-bit letter index, 0..25 = A..Z, else non-letter
//   encrypt_in   in   mode for this letter, 1 = encrypt, 0 = decrypt
//   out_valid    out  output buffer holds a result
//   out_ready    in   downstream consumes the buffered result
//   char_out     out  buffered letter
//   rotor_value  out  buffered offset 0..25
//   encrypt_out  out  buffered mode bit
//   pos0..2      out  current rotor positions

module rotor_sequencer #(
  parameter int NOTCH0 = 25,
  parameter int NOTCH1 = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] init_pos0,
  input  logic [7:0] init_pos1,
  input  logic [7:0] init_pos2,
  output logic       load_err,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] char_in,
  input  logic       encrypt_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] char_out,
  output logic [7:0] rotor_value,
  output logic       encrypt_out,
  output logic [7:0] pos0,
  output logic [7:0] pos1,
  output logic [7:0] pos2
);

  localparam logic [7:0] LAST_POS = 8'd25;
  localparam logic [7:0] NOTCH0_POS = 8'(NOTCH0);
  localparam logic [7:0] NOTCH1_POS = 8'(NOTCH1);

  logic       accept;
  logic       is_letter;
  logic       load_ok;
  logic [8:0] pos_sum;
  logic [7:0] offset;
  logic       carry0;
  logic       carry1;
  logic [7:0] next_pos0;
  logic [7:0] next_pos1;
  logic [7:0] next_pos2;

  // A new letter can enter whenever the buffer is empty or being drained in
  // the same cycle; a load always blocks the handshake.
  assign char_ready = !load && (!out_valid || out_ready);
  assign accept     = char_valid && char_ready;
  assign is_letter  = (char_in <= LAST_POS);
  assign load_ok    = (init_pos0 <= LAST_POS) &&
                      (init_pos1 <= LAST_POS) &&
                      (init_pos2 <= LAST_POS);

  // The sum of three positions is at most 75, so two conditional
  // subtractions are enough to reduce it mod 26 without a divider.
  always_comb begin
    pos_sum = 9'(pos0) + 9'(pos1) + 9'(pos2);
    offset  = 8'd0;
    if (pos_sum >= 9'd52) begin
      offset = 8'(pos_sum - 9'd52);
    end else if (pos_sum >= 9'd26) begin
      offset = 8'(pos_sum - 9'd26);
    end else begin
      offset = 8'(pos_sum);
    end
  end

  // Odometer stepping: rotor 1 only moves on a rotor 0 notch, rotor 2 only
  // when that carry also finds rotor 1 sitting on its notch.
  always_comb begin
    carry0    = (pos0 == NOTCH0_POS);
    carry1    = carry0 && (pos1 == NOTCH1_POS);
    next_pos0 = (pos0 == LAST_POS) ? 8'd0 : pos0 + 8'd1;
    next_pos1 = pos1;
    next_pos2 = pos2;
    if (carry0) begin
      next_pos1 = (pos1 == LAST_POS) ? 8'd0 : pos1 + 8'd1;
    end
    if (carry1) begin
      next_pos2 = (pos2 == LAST_POS) ? 8'd0 : pos2 + 8'd1;
    end
  end

  // Rotor state and load error. A load wins over an accept, and a rejected
  // load leaves the rotors untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos0     <= 8'd0;
      pos1     <= 8'd0;
      pos2     <= 8'd0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          pos0 <= init_pos0;
          pos1 <= init_pos1;
          pos2 <= init_pos2;
        end else begin
          load_err <= 1'b1;
        end
      end else if (accept && is_letter) begin
        pos0 <= next_pos0;
        pos1 <= next_pos1;
        pos2 <= next_pos2;
      end
    end
  end

  // One-entry output buffer. An accept overwrites the entry, including the
  // case where the old entry is consumed on the same edge. A consume with
  // no accept just empties it, and a stalled entry holds its contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      char_out    <= 8'd0;
      rotor_value <= 8'd0;
      encrypt_out <= 1'b0;
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        char_out    <= char_in;
        encrypt_out <= encrypt_in;
        rotor_value <= is_letter ? offset : 8'd0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotor_sequencer.sv
// tb_rotor_sequencer
//
// Purpose:
//   Self-checking bench for rotor_sequencer with default notches (25, 25).
//   Directed scenarios use hand-derived constants. A randomized run is
//   compared against an arithmetic model of the rotors and the output buffer.
//
// Ports: none (top-level bench).

module tb_rotor_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] init_pos0;
  logic [7:0] init_pos1;
  logic [7:0] init_pos2;
  logic       load_err;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_in;
  logic       encrypt_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] char_out;
  logic [7:0] rotor_value;
  logic       encrypt_out;
  logic [7:0] pos0;
  logic [7:0] pos1;
  logic [7:0] pos2;

  int total = 0;
  int bad = 0;

  // Reference model state
  int  m_pos [3];
  bit  m_valid;
  int  m_char;
  int  m_rv;
  bit  m_enc;
  bit  m_err;

  rotor_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .init_pos0   (init_pos0),
    .init_pos1   (init_pos1),
    .init_pos2   (init_pos2),
    .load_err    (load_err),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .char_in     (char_in),
    .encrypt_in  (encrypt_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .char_out    (char_out),
    .rotor_value (rotor_value),
    .encrypt_out (encrypt_out),
    .pos0        (pos0),
    .pos1        (pos1),
    .pos2        (pos2)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_pos[0] = 0;
    m_pos[1] = 0;
    m_pos[2] = 0;
    m_valid = 0;
    m_char = 0;
    m_rv = 0;
    m_enc = 0;
    m_err = 0;
  endtask

  // Predict the state after the next edge from the current inputs.
  task automatic model_edge();
    bit rdy;
    bit c0;
    bit c1;
    rdy = !load && (!m_valid || out_ready);
    m_err = 0;
    if (load) begin
      if (init_pos0 < 26 && init_pos1 < 26 && init_pos2 < 26) begin
        m_pos[0] = init_pos0;
        m_pos[1] = init_pos1;
        m_pos[2] = init_pos2;
      end else begin
        m_err = 1;
      end
    end
    if (char_valid && rdy) begin
      m_valid = 1;
      m_char = char_in;
      m_enc = encrypt_in;
      if (char_in < 26) begin
        m_rv = (m_pos[0] + m_pos[1] + m_pos[2]) % 26;
        c0 = (m_pos[0] == 25);
        c1 = c0 && (m_pos[1] == 25);
        m_pos[0] = (m_pos[0] + 1) % 26;
        if (c0) m_pos[1] = (m_pos[1] + 1) % 26;
        if (c1) m_pos[2] = (m_pos[2] + 1) % 26;
      end else begin
        m_rv = 0;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic idle_inputs();
    load = 0;
    init_pos0 = 0;
    init_pos1 = 0;
    init_pos2 = 0;
    char_valid = 0;
    char_in = 0;
    encrypt_in = 0;
    out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #2;
    total++;
    if ({out_valid, char_out, rotor_value, encrypt_out, load_err, pos0, pos1, pos2} !== 45'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got valid=%0b char=%0d rv=%0d enc=%0b err=%0b pos=%0d,%0d,%0d expected all 0",
               out_valid, char_out, rotor_value, encrypt_out, load_err, pos0, pos1, pos2);
    end
    total++;
    if (char_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready got %0b expected 1", char_ready);
    end
    tick();
    reset = 0;
  endtask

  task automatic test_basic_stepping();
    int letters [3] = '{7, 4, 11};
    load = 1;
    tick();
    load = 0;
    char_valid = 1;
    encrypt_in = 1;
    for (int i = 0; i < 3; i++) begin
      char_in = 8'(letters[i]);
      tick();
      total++;
      if (out_valid !== 1'b1 || char_out !== 8'(letters[i]) || rotor_value !== 8'(i) || encrypt_out !== 1'b1) begin
        bad++;
        $display("[TB] FAIL basic_letter%0d got valid=%0b char=%0d rv=%0d enc=%0b expected 1,%0d,%0d,1",
                 i, out_valid, char_out, rotor_value, encrypt_out, letters[i], i);
      end
    end
    char_valid = 0;
    total++;
    if (pos0 !== 8'd3 || pos1 !== 8'd0 || pos2 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL basic_pos got %0d,%0d,%0d expected 3,0,0", pos0, pos1, pos2);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_drain got out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_double_carry();
    load = 1;
    init_pos0 = 25;
    init_pos1 = 25;
    init_pos2 = 3;
    tick();
    load = 0;
    char_in = 0;
    encrypt_in = 0;
    char_valid = 1;
    tick();
    char_valid = 0;
    total++;
    if (out_valid !== 1'b1 || char_out !== 8'd0 || rotor_value !== 8'd1 || encrypt_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL carry_out got valid=%0b char=%0d rv=%0d enc=%0b expected 1,0,1,0",
               out_valid, char_out, rotor_value, encrypt_out);
    end
    total++;
    if (pos0 !== 8'd0 || pos1 !== 8'd0 || pos2 !== 8'd4) begin
      bad++;
      $display("[TB] FAIL carry_pos got %0d,%0d,%0d expected 0,0,4", pos0, pos1, pos2);
    end
  endtask

  task automatic test_non_letter();
    load = 1;
    init_pos0 = 5;
    init_pos1 = 1;
    init_pos2 = 0;
    tick();
    load = 0;
    char_in = 32;
    encrypt_in = 1;
    char_valid = 1;
    tick();
    char_valid = 0;
    total++;
    if (out_valid !== 1'b1 || char_out !== 8'd32 || rotor_value !== 8'd0 || encrypt_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nonletter_out got valid=%0b char=%0d rv=%0d enc=%0b expected 1,32,0,1",
               out_valid, char_out, rotor_value, encrypt_out);
    end
    total++;
    if (pos0 !== 8'd5 || pos1 !== 8'd1 || pos2 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL nonletter_pos got %0d,%0d,%0d expected 5,1,0", pos0, pos1, pos2);
    end
  endtask

  task automatic test_backpressure();
    // Positions are (5,1,0): letter 10 gets offset 6 and steps to (6,1,0).
    char_in = 10;
    encrypt_in = 0;
    char_valid = 1;
    out_ready = 1;
    tick();
    out_ready = 0;
    char_in = 3;
    encrypt_in = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (char_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_ready cycle%0d got %0b expected 0", i, char_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || char_out !== 8'd10 || rotor_value !== 8'd6 || encrypt_out !== 1'b0 ||
          pos0 !== 8'd6 || pos1 !== 8'd1 || pos2 !== 8'd0) begin
        bad++;
        $display("[TB] FAIL stall_hold cycle%0d got valid=%0b char=%0d rv=%0d enc=%0b pos=%0d,%0d,%0d expected 1,10,6,0 pos 6,1,0",
                 i, out_valid, char_out, rotor_value, encrypt_out, pos0, pos1, pos2);
      end
    end
    out_ready = 1;
    #1;
    total++;
    if (char_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL release_ready got %0b expected 1", char_ready);
    end
    tick();
    char_valid = 0;
    total++;
    if (out_valid !== 1'b1 || char_out !== 8'd3 || rotor_value !== 8'd7 || encrypt_out !== 1'b1 ||
        pos0 !== 8'd7 || pos1 !== 8'd1 || pos2 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL release_accept got valid=%0b char=%0d rv=%0d enc=%0b pos=%0d,%0d,%0d expected 1,3,7,1 pos 7,1,0",
               out_valid, char_out, rotor_value, encrypt_out, pos0, pos1, pos2);
    end
  endtask

  task automatic test_load();
    // Positions are (7,1,0) with a pending entry that drains on this edge.
    load = 1;
    init_pos0 = 3;
    init_pos1 = 26;
    init_pos2 = 0;
    tick();
    load = 0;
    total++;
    if (load_err !== 1'b1 || pos0 !== 8'd7 || pos1 !== 8'd1 || pos2 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL load_reject got err=%0b pos=%0d,%0d,%0d expected 1 pos 7,1,0",
               load_err, pos0, pos1, pos2);
    end
    tick();
    total++;
    if (load_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_err_pulse got %0b expected 0", load_err);
    end
    load = 1;
    init_pos0 = 12;
    init_pos1 = 13;
    init_pos2 = 14;
    char_valid = 1;
    char_in = 5;
    #1;
    total++;
    if (char_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_blocks_ready got %0b expected 0", char_ready);
    end
    tick();
    load = 0;
    char_valid = 0;
    total++;
    if (out_valid !== 1'b0 || load_err !== 1'b0 || pos0 !== 8'd12 || pos1 !== 8'd13 || pos2 !== 8'd14) begin
      bad++;
      $display("[TB] FAIL load_priority got valid=%0b err=%0b pos=%0d,%0d,%0d expected 0,0 pos 12,13,14",
               out_valid, load_err, pos0, pos1, pos2);
    end
  endtask

  task automatic test_random();
    reset = 1;
    #1;
    reset = 0;
    model_reset();
    idle_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      load = ($urandom_range(0, 9) == 0);
      init_pos0 = 8'($urandom_range(0, 9) == 0 ? $urandom_range(26, 255) : $urandom_range(0, 25));
      init_pos1 = 8'($urandom_range(0, 25));
      init_pos2 = 8'($urandom_range(0, 25));
      char_valid = ($urandom_range(0, 3) != 0);
      char_in = 8'($urandom_range(0, 7) == 0 ? $urandom_range(26, 255) : $urandom_range(0, 25));
      encrypt_in = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (char_ready !== (!load && (!m_valid || out_ready))) begin
        bad++;
        $display("[TB] FAIL rand_ready cycle%0d got %0b expected %0b", cyc, char_ready,
                 !load && (!m_valid || out_ready));
      end
      model_edge();
      tick();
      total++;
      if (out_valid !== m_valid || load_err !== m_err ||
          pos0 !== 8'(m_pos[0]) || pos1 !== 8'(m_pos[1]) || pos2 !== 8'(m_pos[2]) ||
          (m_valid && (char_out !== 8'(m_char) || rotor_value !== 8'(m_rv) || encrypt_out !== m_enc))) begin
        bad++;
        $display("[TB] FAIL rand_state cycle%0d got v=%0b c=%0d rv=%0d e=%0b err=%0b pos=%0d,%0d,%0d expected v=%0b c=%0d rv=%0d e=%0b err=%0b pos=%0d,%0d,%0d",
                 cyc, out_valid, char_out, rotor_value, encrypt_out, load_err, pos0, pos1, pos2,
                 m_valid, m_char, m_rv, m_enc, m_err, m_pos[0], m_pos[1], m_pos[2]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    char_in = 20;
    encrypt_in = 1;
    char_valid = 1;
    out_ready = 1;
    tick();
    char_valid = 0;
    out_ready = 0;
    load = 1;
    init_pos0 = 9;
    init_pos1 = 2;
    init_pos2 = 1;
    tick();
    load = 0;
    total++;
    if (out_valid !== 1'b1 || pos0 !== 8'd9 || pos1 !== 8'd2 || pos2 !== 8'd1) begin
      bad++;
      $display("[TB] FAIL premid_state got valid=%0b pos=%0d,%0d,%0d expected 1 pos 9,2,1",
               out_valid, pos0, pos1, pos2);
    end
    #2;
    reset = 1;
    #1;
    total++;
    if ({out_valid, char_out, rotor_value, encrypt_out, load_err, pos0, pos1, pos2} !== 45'd0) begin
      bad++;
      $display("[TB] FAIL midreset_clear got valid=%0b char=%0d rv=%0d enc=%0b err=%0b pos=%0d,%0d,%0d expected all 0",
               out_valid, char_out, rotor_value, encrypt_out, load_err, pos0, pos1, pos2);
    end
    #1;
    reset = 0;
    out_ready = 1;
    tick();
    total++;
    if (out_valid !== 1'b0 || pos0 !== 8'd0) begin
      bad++;
      $display("[TB] FAIL postreset_idle got valid=%0b pos0=%0d expected 0,0", out_valid, pos0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stepping();
    test_double_carry();
    test_non_letter();
    test_backpressure();
    test_load();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
